dual_port_ram_param: RTL and testbench
======================================

// Module: dual_port_ram_param
// PURPOSE
//   Parametrised true-dual-port synchronous RAM; next-generation replacement for the fixed 16x1k two-port memory.
//   Two independent read/write ports share one clock. Adds registered read with valid strobe, read-during-write mode,
//   write-write collision arbitration, address range checking, and a post-reset zero-fill sequencer with Ready flag.
//   Serves as the data/instruction store for the datapath and as the backing store for the memory-mapped I/O layer.
// PARAMETERS
//   DATA_W    16    data width, bits
//   ADDR_W    16    address port width, bits
//   DEPTH     1024  number of words; must satisfy DEPTH <= 2**ADDR_W
//   RDW_MODE  0     read-during-write to same address: 0 = returns old data (read-first), 1 = returns new data (write-first)
// PORTS
//   CLK         in   1       clock; all state changes on rising edge
//   Reset_n     in   1       asynchronous, active-low reset
//   DataIn_1    in   DATA_W  port 1 write data
//   Address_1   in   ADDR_W  port 1 word address
//   WriteEna_1  in   1       port 1 write request
//   ReadEna_1   in   1       port 1 read request
//   DataOut_1   out  DATA_W  port 1 registered read data
//   Valid_1     out  1       port 1 read data valid, one-cycle pulse
//   AddrErr_1   out  1       port 1 out-of-range access, one-cycle pulse
//   DataIn_2, Address_2, WriteEna_2, ReadEna_2, DataOut_2, Valid_2, AddrErr_2: same as port 1, for port 2
//   Ready       out  1       high once zero-fill is complete; port requests are honoured only when high
//   Collision   out  1       both ports wrote the same address in the previous cycle, one-cycle pulse
// BEHAVIOUR
//   Reset: Reset_n low asynchronously forces DataOut_x=0, Valid_x=0, AddrErr_x=0, Ready=0, Collision=0,
//     FSM=INIT, fill counter=0. Memory contents are undefined until zero-fill completes.
//   FSM INIT: one word written with 0 per cycle at the fill-counter address. All port requests are ignored:
//     no write, no Valid, no AddrErr.
//   FSM INIT -> READY: on the edge that writes address DEPTH-1. Ready=1 after that edge, i.e. after exactly DEPTH
//     clock edges following reset release.
//   FSM READY: remains in READY until Reset_n is asserted. Reset asserted mid-fill restarts the fill from address 0.
//   Write: WriteEna_x high at an edge with Ready=1 and Address_x<DEPTH -> mem[Address_x] = DataIn_x at that edge.
//   Read: ReadEna_x high at edge n -> DataOut_x updated and Valid_x=1 after edge n (latency 1). Valid_x drops the next
//     cycle unless ReadEna_x is held; back-to-back reads give one word per cycle.
//   Idle: with no read, DataOut_x holds its last value.
//   Write-write same address: port 1 data is stored and Collision=1 for one cycle. Different addresses never flag.
//   Read-during-write to the same address (same port or cross-port): DataOut returns old data if RDW_MODE=0, new data
//     if RDW_MODE=1. If port 1 and port 2 write-collide, "new data" is port 1 data.
//   Address_x >= DEPTH: write is dropped. A read returns DataOut_x=0 with Valid_x=1. AddrErr_x=1 for one cycle
//     when either request is active.
//   ReadEna_x and WriteEna_x both high on one port: both are performed, and RDW_MODE applies.
//   Widths: addresses compared unsigned at full ADDR_W; no wrap-around, an out-of-range address never aliases.
// TESTING
//   1 Release reset; count edges -> Ready rises after exactly 1024 edges. Then read 0x03FF on port 1 -> DataOut_1=0x0000, Valid_1 pulse.
//   2 Write port1 0x0005<=0xBEEF; next cycle read port2 0x0005 -> DataOut_2=0xBEEF one cycle later with Valid_2=1 for one cycle.
//   3 Same cycle, port1 0x0010<=0x1111 and port2 0x0010<=0x2222 -> Collision=1 for one cycle; later read 0x0010 -> 0x1111.
//   4 mem[0x0020]=0xAAAA; port1 writes 0x5555 while port2 reads 0x0020 -> DataOut_2=0xAAAA (RDW_MODE=0), 0x5555 (RDW_MODE=1).
//   5 Write port2 0x0400<=0x1234, then read 0x0400 -> AddrErr_2 pulse both times, DataOut_2=0x0000; mem[0x0000] unchanged.
//   6 Assert Reset_n at fill cycle 500 with port writes driven -> outputs clear immediately; Ready only after 1024 further edges; prior writes absent.

Source files
------------

// File: rtl/dual_port_ram_param.sv
// Parametrised true-dual-port synchronous RAM with registered reads, collision arbitration,
// address range checking and a post-reset zero-fill sequencer.
module dual_port_ram_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 1024,
    parameter int RDW_MODE = 0
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] DataIn_1,
    input  logic [ADDR_W-1:0] Address_1,
    input  logic              WriteEna_1,
    input  logic              ReadEna_1,
    output logic [DATA_W-1:0] DataOut_1,
    output logic              Valid_1,
    output logic              AddrErr_1,
    input  logic [DATA_W-1:0] DataIn_2,
    input  logic [ADDR_W-1:0] Address_2,
    input  logic              WriteEna_2,
    input  logic              ReadEna_2,
    output logic [DATA_W-1:0] DataOut_2,
    output logic              Valid_2,
    output logic              AddrErr_2,
    output logic              Ready,
    output logic              Collision
);

    localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  fillCnt_q, fillCnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] dataOut1_q, dataOut1_d, dataOut2_q, dataOut2_d;
    logic              valid1_q, valid1_d, valid2_q, valid2_d;
    logic              addrErr1_q, addrErr1_d, addrErr2_q, addrErr2_d;
    logic              collision_q, collision_d;

    logic              isReady, inRange1, inRange2, sameIdx;
    logic              wr1, wr2, rd1, rd2;
    logic [IDX_W-1:0]  idx1, idx2;
    logic [DATA_W-1:0] rdData1, rdData2;

    // Range check is done one bit wider so DEPTH == 2**ADDR_W cannot overflow the compare.
    assign isReady  = (state_q == READY);
    assign inRange1 = ({1'b0, Address_1} < DEPTH_X);
    assign inRange2 = ({1'b0, Address_2} < DEPTH_X);
    assign idx1     = Address_1[IDX_W-1:0];
    assign idx2     = Address_2[IDX_W-1:0];
    assign sameIdx  = (idx1 == idx2);
    assign wr1      = isReady && WriteEna_1 && inRange1;
    assign wr2      = isReady && WriteEna_2 && inRange2 && !(wr1 && sameIdx);
    assign rd1      = isReady && ReadEna_1;
    assign rd2      = isReady && ReadEna_2;

    // Write-first mode forwards incoming write data; port 1 is applied last so it wins.
    always_comb begin
        rdData1 = '0;
        rdData2 = '0;
        if (inRange1) begin
            rdData1 = mem[idx1];
            if (RDW_MODE != 0) begin
                if (wr2 && sameIdx) rdData1 = DataIn_2;
                if (wr1)            rdData1 = DataIn_1;
            end
        end
        if (inRange2) begin
            rdData2 = mem[idx2];
            if (RDW_MODE != 0) begin
                if (wr2)            rdData2 = DataIn_2;
                if (wr1 && sameIdx) rdData2 = DataIn_1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!isReady) begin
            mem[fillCnt_q] <= '0;
        end else begin
            if (wr1) mem[idx1] <= DataIn_1;
            if (wr2) mem[idx2] <= DataIn_2;
        end
    end

    always_comb begin
        state_d     = state_q;
        fillCnt_d   = fillCnt_q;
        dataOut1_d  = rd1 ? rdData1 : dataOut1_q;
        dataOut2_d  = rd2 ? rdData2 : dataOut2_q;
        valid1_d    = rd1;
        valid2_d    = rd2;
        addrErr1_d  = isReady && (ReadEna_1 || WriteEna_1) && !inRange1;
        addrErr2_d  = isReady && (ReadEna_2 || WriteEna_2) && !inRange2;
        collision_d = isReady && WriteEna_1 && WriteEna_2 && inRange1 && inRange2 && sameIdx;
        case (state_q)
            INIT: begin
                fillCnt_d = fillCnt_q + 1'b1;
                if (fillCnt_q == LAST_IDX) begin
                    state_d   = READY;
                    fillCnt_d = '0;
                end
            end
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= INIT;
            fillCnt_q   <= '0;
            dataOut1_q  <= '0;
            dataOut2_q  <= '0;
            valid1_q    <= 1'b0;
            valid2_q    <= 1'b0;
            addrErr1_q  <= 1'b0;
            addrErr2_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fillCnt_q   <= fillCnt_d;
            dataOut1_q  <= dataOut1_d;
            dataOut2_q  <= dataOut2_d;
            valid1_q    <= valid1_d;
            valid2_q    <= valid2_d;
            addrErr1_q  <= addrErr1_d;
            addrErr2_q  <= addrErr2_d;
            collision_q <= collision_d;
        end
    end

    assign DataOut_1 = dataOut1_q;
    assign DataOut_2 = dataOut2_q;
    assign Valid_1   = valid1_q;
    assign Valid_2   = valid2_q;
    assign AddrErr_1 = addrErr1_q;
    assign AddrErr_2 = addrErr2_q;
    assign Collision = collision_q;
    assign Ready     = isReady;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench for dual_port_ram_param: one read-first and one write-first instance share
// the same stimulus so read-during-write behaviour can be compared side by side.
module tb_dual_port_ram_param;

    logic        clk = 1'b0;
    logic        rstN;
    logic [15:0] din1, addr1, din2, addr2;
    logic        we1, re1, we2, re2;

    logic [15:0] doutA1, doutA2, doutB1, doutB2;
    logic        validA1, validA2, validB1, validB2;
    logic        errA1, errA2, errB1, errB2;
    logic        readyA, readyB, collA, collB;

    int testCnt = 0;
    int failCnt = 0;
    int edges;

    always #5 clk = ~clk;

    dual_port_ram_param #(.RDW_MODE(0)) dutA (
        .CLK(clk), .Reset_n(rstN),
        .DataIn_1(din1), .Address_1(addr1), .WriteEna_1(we1), .ReadEna_1(re1),
        .DataOut_1(doutA1), .Valid_1(validA1), .AddrErr_1(errA1),
        .DataIn_2(din2), .Address_2(addr2), .WriteEna_2(we2), .ReadEna_2(re2),
        .DataOut_2(doutA2), .Valid_2(validA2), .AddrErr_2(errA2),
        .Ready(readyA), .Collision(collA)
    );

    dual_port_ram_param #(.RDW_MODE(1)) dutB (
        .CLK(clk), .Reset_n(rstN),
        .DataIn_1(din1), .Address_1(addr1), .WriteEna_1(we1), .ReadEna_1(re1),
        .DataOut_1(doutB1), .Valid_1(validB1), .AddrErr_1(errB1),
        .DataIn_2(din2), .Address_2(addr2), .WriteEna_2(we2), .ReadEna_2(re2),
        .DataOut_2(doutB2), .Valid_2(validB2), .AddrErr_2(errB2),
        .Ready(readyB), .Collision(collB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w1, input logic r1, input logic [15:0] a1, input logic [15:0] d1,
                                 input logic w2, input logic r2, input logic [15:0] a2, input logic [15:0] d2);
        we1 = w1; re1 = r1; addr1 = a1; din1 = d1;
        we2 = w2; re2 = r2; addr2 = a2; din2 = d2;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic waitReady(input string tag);
        edges = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            edges++;
            if (readyA && readyB) break;
        end
        checkOutput(tag, 32'(edges), 32'd1024);
    endtask

    initial begin
        rstN = 1'b0;
        idle();
        tick();
        tick();
        checkOutput("rst_dout1", {16'h0, doutA1}, 32'h0);
        checkOutput("rst_valid1", {31'h0, validA1}, 32'h0);
        checkOutput("rst_ready", {30'h0, readyA, readyB}, 32'h0);
        checkOutput("rst_coll", {30'h0, collA, collB}, 32'h0);

        // Test 1: fill length and zero contents at the last word.
        rstN = 1'b1;
        waitReady("fill_edges");
        applyStimulus(0, 1, 16'h03FF, 16'h0, 0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("t1_dout", {doutA1, doutB1}, 32'h0000_0000);
        checkOutput("t1_valid", {30'h0, validA1, validB1}, 32'h3);
        idle();
        tick();
        checkOutput("t1_valid_drop", {30'h0, validA1, validB1}, 32'h0);

        // Test 2: write then cross-port read, valid pulse and hold.
        applyStimulus(1, 0, 16'h0005, 16'hBEEF, 0, 0, 16'h0, 16'h0);
        tick();
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 1, 16'h0005, 16'h0);
        tick();
        checkOutput("t2_dout", {doutA2, doutB2}, 32'hBEEF_BEEF);
        checkOutput("t2_valid", {30'h0, validA2, validB2}, 32'h3);
        idle();
        tick();
        checkOutput("t2_valid_drop", {30'h0, validA2, validB2}, 32'h0);
        checkOutput("t2_hold", {doutA2, doutB2}, 32'hBEEF_BEEF);

        // Test 3: same-address collision, then different addresses.
        applyStimulus(1, 0, 16'h0010, 16'h1111, 1, 0, 16'h0010, 16'h2222);
        tick();
        checkOutput("t3_coll", {30'h0, collA, collB}, 32'h3);
        applyStimulus(1, 0, 16'h0011, 16'h3333, 1, 0, 16'h0012, 16'h4444);
        tick();
        checkOutput("t3_nocoll", {30'h0, collA, collB}, 32'h0);
        applyStimulus(0, 1, 16'h0010, 16'h0, 0, 1, 16'h0012, 16'h0);
        tick();
        checkOutput("t3_winner", {doutA1, doutB1}, 32'h1111_1111);
        checkOutput("t3_port2_word", {doutA2, doutB2}, 32'h4444_4444);
        applyStimulus(0, 1, 16'h0011, 16'h0, 0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("t3_port1_word", {doutA1, doutB1}, 32'h3333_3333);

        // Test 4: cross-port read-during-write, then same-port read-during-write.
        applyStimulus(1, 0, 16'h0020, 16'hAAAA, 0, 0, 16'h0, 16'h0);
        tick();
        applyStimulus(1, 0, 16'h0020, 16'h5555, 0, 1, 16'h0020, 16'h0);
        tick();
        checkOutput("t4_rdw_cross", {doutA2, doutB2}, 32'hAAAA_5555);
        applyStimulus(1, 1, 16'h0030, 16'h7777, 0, 1, 16'h0020, 16'h0);
        tick();
        checkOutput("t4_rdw_same", {doutA1, doutB1}, 32'h0000_7777);
        checkOutput("t4_after", {doutA2, doutB2}, 32'h5555_5555);

        // Test 5: out-of-range write and read.
        applyStimulus(0, 0, 16'h0, 16'h0, 1, 0, 16'h0400, 16'h1234);
        tick();
        checkOutput("t5_err_wr", {30'h0, errA2, errB2}, 32'h3);
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 1, 16'h0400, 16'h0);
        tick();
        checkOutput("t5_err_rd", {30'h0, errA2, errB2}, 32'h3);
        checkOutput("t5_dout", {doutA2, doutB2}, 32'h0);
        checkOutput("t5_valid", {30'h0, validA2, validB2}, 32'h3);
        applyStimulus(0, 1, 16'h0000, 16'h0, 0, 1, 16'hFFFF, 16'h0);
        tick();
        checkOutput("t5_no_alias", {doutA1, doutB1}, 32'h0);
        checkOutput("t5_err_ffff", {28'h0, errA1, errB1, errA2, errB2}, 32'h3);
        idle();
        tick();
        checkOutput("t5_err_drop", {28'h0, errA1, errB1, errA2, errB2}, 32'h0);

        // Test 6: asynchronous reset, mid-fill reset, and lost contents.
        applyStimulus(0, 1, 16'h0005, 16'h0, 0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("t6_pre", {doutA1, doutB1}, 32'hBEEF_BEEF);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("t6_async_dout", {doutA1, doutB1}, 32'h0);
        checkOutput("t6_async_flags", {28'h0, validA1, validB1, readyA, readyB}, 32'h0);
        tick();
        rstN = 1'b1;
        applyStimulus(1, 0, 16'h0005, 16'h9999, 1, 0, 16'h0006, 16'h8888);
        for (int i = 0; i < 500; i++) tick();
        checkOutput("t6_midfill_ready", {30'h0, readyA, readyB}, 32'h0);
        rstN = 1'b0;
        #1;
        checkOutput("t6_midfill_rst", {30'h0, readyA, readyB}, 32'h0);
        tick();
        rstN = 1'b1;
        waitReady("t6_refill_edges");
        applyStimulus(0, 1, 16'h0005, 16'h0, 0, 1, 16'h0010, 16'h0);
        tick();
        checkOutput("t6_cleared5", {doutA1, doutB1}, 32'h0);
        checkOutput("t6_cleared10", {doutA2, doutB2}, 32'h0);
        checkOutput("t6_valid", {28'h0, validA1, validB1, validA2, validB2}, 32'hF);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
